// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Pipeline stall/flush control for load-use, branch and memory waits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_stall_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        icache_busy,
    input  logic        dcache_busy,
    input  logic        clr_cnt,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_flush,
    output logic        id_ex_bubble,
    output logic        proc_stall,
    output logic [15:0] stall_cnt,
    output logic [7:0]  lu_cnt,
    output logic [7:0]  flush_cnt,
    output logic        err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_HOLD  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'd254;

    state_t      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [7:0]  lu_cnt_q, lu_cnt_d;
    logic [7:0]  flush_cnt_q, flush_cnt_d;
    logic        err_q, err_d;

    logic mem_busy;
    logic load_use;
    logic pc_write_c, if_id_write_c, if_flush_c, bubble_c;

    assign mem_busy = icache_busy | dcache_busy;
    assign load_use = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_comb begin
        state_d       = state_q;
        pc_write_c    = 1'b0;
        if_id_write_c = 1'b0;
        if_flush_c    = 1'b0;
        bubble_c      = 1'b0;
        if (mem_busy) begin
            state_d = MEM_WAIT;
        end else if (load_use && (state_q != LU_HOLD)) begin
            // The cycle after a bubble ignores the still-visible hazard.
            bubble_c = 1'b1;
            state_d  = LU_HOLD;
        end else begin
            pc_write_c    = 1'b1;
            if_id_write_c = 1'b1;
            if_flush_c    = branch_taken;
            state_d       = RUN;
        end
    end

    // Outputs are forced to their frozen values while reset is held.
    assign pc_write     = rst_n & pc_write_c;
    assign if_id_write  = rst_n & if_id_write_c;
    assign if_flush     = rst_n & if_flush_c;
    assign id_ex_bubble = rst_n & bubble_c;
    assign proc_stall   = mem_busy | ~rst_n;

    always_comb begin
        wait_d      = 8'd0;
        stall_cnt_d = stall_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        flush_cnt_d = flush_cnt_q;
        err_d       = err_q;
        if (state_q == MEM_WAIT) begin
            wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        end
        if (clr_cnt) begin
            stall_cnt_d = 16'd0;
            lu_cnt_d    = 8'd0;
            flush_cnt_d = 8'd0;
            err_d       = 1'b0;
        end else begin
            if (mem_busy && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
            if (bubble_c && (lu_cnt_q != 8'hFF))       lu_cnt_d    = lu_cnt_q + 8'd1;
            if (if_flush_c && (flush_cnt_q != 8'hFF))  flush_cnt_d = flush_cnt_q + 8'd1;
            // Timeout when this MEM_WAIT cycle brings the wait count to 255.
            if ((state_q == MEM_WAIT) && mem_busy && (wait_q >= WAIT_LIMIT)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            wait_q      <= 8'd0;
            stall_cnt_q <= 16'd0;
            lu_cnt_q    <= 8'd0;
            flush_cnt_q <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            stall_cnt_q <= stall_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign lu_cnt    = lu_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Scoreboard bench for hazard_stall_ctrl against a cycle-level model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        ex_memread = 1'b0, branch_taken = 1'b0;
    logic        icache_busy = 1'b0, dcache_busy = 1'b0, clr_cnt = 1'b0;
    logic        pc_write, if_id_write, if_flush, id_ex_bubble, proc_stall, err;
    logic [15:0] stall_cnt;
    logic [7:0]  lu_cnt, flush_cnt;

    hazard_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .branch_taken(branch_taken),
        .icache_busy(icache_busy), .dcache_busy(dcache_busy), .clr_cnt(clr_cnt),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
        .id_ex_bubble(id_ex_bubble), .proc_stall(proc_stall),
        .stall_cnt(stall_cnt), .lu_cnt(lu_cnt), .flush_cnt(flush_cnt), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pc, ifid, flush, bub, stall;
        logic [15:0] sc;
        logic [7:0]  lc, fc;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;

    // Reference model state: whether the previous cycle issued a bubble,
    // length of the current busy run, and the visible counters.
    bit          m_prev_bub = 1'b0;
    int          m_run = 0;
    int          m_sc = 0, m_lc = 0, m_fc = 0;
    bit          m_err = 1'b0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    // Drives one cycle of stimulus and queues the expected response.
    task automatic step(input bit rn, input bit mr, input int ert, input int rs, input int rt,
                        input bit br, input bit ib, input bit db, input bit clr);
        exp_t e;
        bit   busy, haz;
        @(posedge clk);
        #1;
        rst_n = rn; ex_memread = mr; ex_rt = 5'(ert); id_rs = 5'(rs); id_rt = 5'(rt);
        branch_taken = br; icache_busy = ib; dcache_busy = db; clr_cnt = clr;
        busy = ib | db;
        haz  = mr && (ert != 0) && ((ert == rs) || (ert == rt));
        if (!rn) begin
            e = '{pc:1'b0, ifid:1'b0, flush:1'b0, bub:1'b0, stall:1'b1, sc:16'd0, lc:8'd0, fc:8'd0, er:1'b0};
            exp_q.push_back(e);
            m_prev_bub = 1'b0; m_run = 0; m_sc = 0; m_lc = 0; m_fc = 0; m_err = 1'b0;
        end else begin
            e.sc = 16'(m_sc); e.lc = 8'(m_lc); e.fc = 8'(m_fc); e.er = m_err;
            e.stall = busy;
            e.pc = 1'b0; e.ifid = 1'b0; e.flush = 1'b0; e.bub = 1'b0;
            if (!busy) begin
                if (haz && !m_prev_bub) e.bub = 1'b1;
                else begin e.pc = 1'b1; e.ifid = 1'b1; e.flush = br; end
            end
            exp_q.push_back(e);
            m_prev_bub = e.bub;
            m_run = busy ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
            if (clr) begin
                m_sc = 0; m_lc = 0; m_fc = 0; m_err = 1'b0;
            end else begin
                if (busy)    m_sc = (m_sc < 65535) ? m_sc + 1 : 65535;
                if (e.bub)   m_lc = (m_lc < 255) ? m_lc + 1 : 255;
                if (e.flush) m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                // The first busy cycle is spent outside MEM_WAIT; the 255th MEM_WAIT
                // cycle is therefore busy-run cycle 256.
                if (busy && m_run >= 256) m_err = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        while (!done) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_write",     16'(pc_write),     16'(e.pc));
                check("if_id_write",  16'(if_id_write),  16'(e.ifid));
                check("if_flush",     16'(if_flush),     16'(e.flush));
                check("id_ex_bubble", 16'(id_ex_bubble), 16'(e.bub));
                check("proc_stall",   16'(proc_stall),   16'(e.stall));
                check("stall_cnt",    stall_cnt,         e.sc);
                check("lu_cnt",       16'(lu_cnt),       16'(e.lc));
                check("flush_cnt",    16'(flush_cnt),    16'(e.fc));
                check("err",          16'(err),          16'(e.er));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int r;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Load-use held for two cycles
        step(1, 1, 8, 8, 0, 0, 0, 0, 0);
        step(1, 1, 8, 8, 0, 0, 0, 0, 0);
        idle(2);
        // Zero register never hazards
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Memory wait overrides hazard and branch, bubble follows
        for (int i = 0; i < 3; i++) step(1, 1, 5, 3, 5, 1, 0, 1, 0);
        step(1, 1, 5, 3, 5, 1, 0, 0, 0);
        step(1, 1, 5, 3, 5, 0, 0, 0, 0);
        idle(2);
        // Branch pulse
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle(2);
        // Bubble then immediate memory wait: hazard re-evaluated afterwards
        step(1, 1, 7, 7, 0, 0, 0, 0, 0);
        step(1, 1, 7, 7, 0, 0, 1, 0, 0);
        step(1, 1, 7, 7, 0, 0, 0, 0, 0);
        step(1, 1, 7, 7, 0, 0, 0, 0, 0);
        idle(2);
        // Long instruction-cache wait to timeout, then clear
        for (int i = 0; i < 260; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            step(r >= 3, $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
        end
        idle(2);
        // Saturation of stall_cnt, then reset in the middle of the wait
        for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        step(1, 1, 9, 0, 9, 0, 0, 0, 0);
        idle(2);
        @(negedge clk);
        #1;
        done = 1'b1;
        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
